// File: rtl/cyber_player_if.sv
// -----------------------------------------------------------------------------
// cyber_player_if
// Control/status bundle between the computer opponent and its environment.
//   enable      : decision ticks run while high; divider frozen while low
//   thresh[8:0] : difficulty, press probability per tick is thresh/512
//   key_n       : emulated active-low key level (1 = released)
//   press_pulse : one-cycle strobe on the first cycle of each press
//   press_count : presses since reset, wraps 255 -> 0
// master = environment/driver side, slave = cyber_player side.
// -----------------------------------------------------------------------------
interface cyber_player_if;
  logic       enable;
  logic [8:0] thresh;
  logic       key_n;
  logic       press_pulse;
  logic [7:0] press_count;

  modport master (
    output enable,
    output thresh,
    input  key_n,
    input  press_pulse,
    input  press_count
  );

  modport slave (
    input  enable,
    input  thresh,
    output key_n,
    output press_pulse,
    output press_count
  );
endinterface

// File: rtl/cyber_player.sv
// -----------------------------------------------------------------------------
// cyber_player
// Computer opponent for the tug-of-war game. A clock divider produces slow
// decision ticks; on each tick a 10-bit XNOR LFSR (x^10+x^7+1) is compared to
// the difficulty threshold and, if below it, the emulated key is pressed for
// HOLD_CYCLES cycles followed by a released gap of HOLD_CYCLES cycles.
// Ports:
//   clk   : system clock
//   Reset : synchronous, active-high reset
//   bus   : cyber_player_if.slave (enable, thresh in; key_n, press_pulse,
//           press_count out, all outputs registered)
// -----------------------------------------------------------------------------
module cyber_player #(
  parameter int TICK_DIV    = 50000,
  parameter int HOLD_CYCLES = 4
) (
  input  logic           clk,
  input  logic           Reset,
  cyber_player_if.slave  bus
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_d;
  logic [9:0]        lfsr_q;
  logic [9:0]        lfsr_d;
  logic              tick_s;
  logic              hit_s;
  state_t            state_q;
  logic [HOLD_W-1:0] hold_q;
  logic              key_q;
  logic              pulse_q;
  logic [7:0]        count_q;

  // Divider next state, tick/hit decode and LFSR advance.
  always_comb begin
    tick_s = 1'b0;
    hit_s  = 1'b0;
    div_d  = div_q;
    lfsr_d = lfsr_q;
    if (bus.enable) begin
      if (div_q == DIV_MAX) begin
        tick_s = 1'b1;
        div_d  = {DIV_W{1'b0}};
      end else begin
        div_d  = div_q + DIV_W'(1);
      end
    end else begin
      div_d = div_q;
    end
    // The compare uses the pre-advance LFSR value; the LFSR steps on every
    // tick, even while a press is in progress.
    if (tick_s) begin
      hit_s  = (lfsr_q[8:0] < bus.thresh);
      lfsr_d = {lfsr_q[8:0], ~(lfsr_q[9] ^ lfsr_q[6])};
    end else begin
      hit_s  = 1'b0;
      lfsr_d = lfsr_q;
    end
  end

  // Divider and LFSR registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      div_q  <= {DIV_W{1'b0}};
      lfsr_q <= 10'h000;
    end else begin
      div_q  <= div_d;
      lfsr_q <= lfsr_d;
    end
  end

  // Press sequencer: IDLE -> PRESS (key low) -> GAP (key high) -> IDLE.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      hold_q  <= {HOLD_W{1'b0}};
      key_q   <= 1'b1;
      pulse_q <= 1'b0;
      count_q <= 8'd0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hit_s) begin
            state_q <= ST_PRESS;
            key_q   <= 1'b0;
            pulse_q <= 1'b1;
            count_q <= count_q + 8'd1;
            hold_q  <= {HOLD_W{1'b0}};
          end else begin
            key_q   <= 1'b1;
          end
        end
        ST_PRESS: begin
          if (hold_q == HOLD_MAX) begin
            state_q <= ST_GAP;
            key_q   <= 1'b1;
            hold_q  <= {HOLD_W{1'b0}};
          end else begin
            hold_q  <= hold_q + HOLD_W'(1);
          end
        end
        ST_GAP: begin
          if (hold_q == HOLD_MAX) begin
            state_q <= ST_IDLE;
            hold_q  <= {HOLD_W{1'b0}};
          end else begin
            hold_q  <= hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          hold_q  <= {HOLD_W{1'b0}};
          key_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.key_n       = key_q;
  assign bus.press_pulse = pulse_q;
  assign bus.press_count = count_q;

endmodule

// File: tb/tb_cyber_player.sv
// -----------------------------------------------------------------------------
// tb_cyber_player
// Two instances: A (TICK_DIV=8, HOLD_CYCLES=2) and B (TICK_DIV=2,
// HOLD_CYCLES=4), driven with the same enable/thresh/Reset. Each cycle both
// are compared against a reference model that tracks only "cycles elapsed
// since the press began" (0 = idle) instead of a state machine.
// -----------------------------------------------------------------------------
module tb_cyber_player;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [8:0] th;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cyber_player_if if_a ();
  cyber_player_if if_b ();

  assign if_a.enable = en;
  assign if_a.thresh = th;
  assign if_b.enable = en;
  assign if_b.thresh = th;

  cyber_player #(.TICK_DIV(8), .HOLD_CYCLES(2)) u_dut_a (
    .clk   (clk),
    .Reset (rst),
    .bus   (if_a.slave)
  );

  cyber_player #(.TICK_DIV(2), .HOLD_CYCLES(4)) u_dut_b (
    .clk   (clk),
    .Reset (rst),
    .bus   (if_b.slave)
  );

  // ---------------- reference model ----------------
  int m_div  [2];
  int m_lfsr [2];
  int m_ph   [2];   // 0 idle, 1..2H cycles into the press+gap sequence
  int m_cnt  [2];
  int b_last_pulse;
  int step_no;

  function automatic int td(input int k);
    return (k == 0) ? 8 : 2;
  endfunction

  function automatic int hd(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_div[k] = 0; m_lfsr[k] = 0; m_ph[k] = 0; m_cnt[k] = 0;
      end else begin
        bit tk;
        bit ht;
        tk = en && (m_div[k] == td(k) - 1);
        ht = tk && ((m_lfsr[k] % 512) < int'(th));
        if (en) m_div[k] = (m_div[k] + 1) % td(k);
        if (tk)
          m_lfsr[k] = ((m_lfsr[k] * 2) % 1024) +
                      ((((m_lfsr[k] >> 9) & 1) == ((m_lfsr[k] >> 6) & 1)) ? 1 : 0);
        if (m_ph[k] == 0) begin
          if (ht) begin
            m_ph[k]  = 1;
            m_cnt[k] = (m_cnt[k] + 1) % 256;
          end
        end else if (m_ph[k] == 2 * hd(k)) begin
          m_ph[k] = 0;
        end else begin
          m_ph[k] = m_ph[k] + 1;
        end
      end
    end
  endtask

  function automatic logic [31:0] model_out(input int k);
    logic key;
    logic pls;
    key = !(m_ph[k] >= 1 && m_ph[k] <= hd(k));
    pls = (m_ph[k] == 1);
    return {22'd0, key, pls, 8'(m_cnt[k])};
  endfunction

  // One clock edge: advance the model, then compare both DUTs after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    step_no++;
    #1;
    chk("a_outputs", {22'd0, if_a.key_n, if_a.press_pulse, if_a.press_count}, model_out(0));
    chk("b_outputs", {22'd0, if_b.key_n, if_b.press_pulse, if_b.press_count}, model_out(1));
    if (rst) begin
      b_last_pulse = -1;
    end else if (if_b.press_pulse === 1'b1) begin
      if (b_last_pulse >= 0) chk("b_pulse_gap_ge8", 32'(step_no - b_last_pulse >= 8), 32'd1);
      b_last_pulse = step_no;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Steps until A shows a pulse; returns the number of edges taken.
  task automatic wait_pulse_a(input int limit, output int n);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      n++;
      if (if_a.press_pulse === 1'b1) return;
    end
    chk("a_pulse_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; th = 9'd0;
    step_no = 0;
    b_last_pulse = -1;

    // Reset state.
    do_reset();
    chk("rst_key_n", {31'd0, if_a.key_n}, 32'd1);
    chk("rst_pulse", {31'd0, if_a.press_pulse}, 32'd0);
    chk("rst_count", {24'd0, if_a.press_count}, 32'd0);

    // Zero difficulty: never presses.
    en = 1'b1; th = 9'd0;
    for (int i = 0; i < 200; i++) step();
    chk("zero_thr_count_a", {24'd0, if_a.press_count}, 32'd0);
    chk("zero_thr_count_b", {24'd0, if_b.press_count}, 32'd0);

    // Maximum difficulty: first pulse on the 8th edge after reset release.
    do_reset();
    th = 9'd511;
    wait_pulse_a(50, n);
    chk("max_first_pulse_lat", 32'(n), 32'd8);
    chk("max_first_key_low", {31'd0, if_a.key_n}, 32'd0);
    for (int i = n; i < 80; i++) step();
    chk("max_count_10_ticks", {24'd0, if_a.press_count}, 32'd10);

    // Threshold 2: only the first two LFSR values (0x000, 0x001) hit.
    do_reset();
    th = 9'd2;
    for (int i = 0; i < 80; i++) step();
    chk("thr2_count_10_ticks", {24'd0, if_a.press_count}, 32'd2);

    // Enable dropped on the second cycle of a press.
    do_reset();
    th = 9'd511;
    wait_pulse_a(50, n);
    en = 1'b0;
    for (int i = 0; i < 40; i++) step();
    chk("endrop_count", {24'd0, if_a.press_count}, 32'd1);
    chk("endrop_key_rel", {31'd0, if_a.key_n}, 32'd1);
    en = 1'b1;
    for (int i = 0; i < 30; i++) step();

    // Reset in the middle of a press.
    wait_pulse_a(50, n);
    step();
    rst = 1'b1;
    step();
    chk("midrst_key_n", {31'd0, if_a.key_n}, 32'd1);
    chk("midrst_pulse", {31'd0, if_a.press_pulse}, 32'd0);
    chk("midrst_count", {24'd0, if_a.press_count}, 32'd0);
    rst = 1'b0;
    wait_pulse_a(50, n);
    chk("midrst_first_pulse_lat", 32'(n), 32'd8);

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0: th = 9'd0;
          1: th = 9'd511;
          default: th = 9'($urandom_range(0, 511));
        endcase
      end
      if ($urandom_range(0, 24) == 0) en = ~en;
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
